// File: rtl/axi_lite_arbiter_if.sv
// axi_lite_if: AXI4-Lite channel bundle shared by masters, arbiter and slave
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: grants one shared AXI4-Lite slave to m0 or m1 for one whole transaction
module axi_lite_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic       clk,
    input logic       reset,
    axi_lite_if.slave  m0,
    axi_lite_if.slave  m1,
    axi_lite_if.master s
);
    typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR} state_t;
    state_t r_state;
    logic   r_owner;
    logic   r_last_grant;
    logic   r_ar_done;
    logic   r_aw_done;
    logic   r_w_done;
    logic   w_wr0;
    logic   w_wr1;
    logic   w_req0;
    logic   w_req1;
    logic   w_winner;
    logic   w_win_wr;
    logic   w_rd;
    logic   w_wr;
    logic   w_s_arvalid;
    logic   w_s_rready;
    logic   w_s_awvalid;
    logic   w_s_wvalid;
    logic   w_s_bready;
    logic   w_arready;
    logic   w_awready;
    logic   w_wready;
    logic   w_rvalid;
    logic   w_bvalid;
    assign w_wr0  = m0.awvalid | m0.wvalid;
    assign w_wr1  = m1.awvalid | m1.wvalid;
    assign w_req0 = m0.arvalid | w_wr0;
    assign w_req1 = m1.arvalid | w_wr1;
    // on a tie round-robin favours whoever was not granted last
    assign w_winner = (w_req0 & w_req1) ? (FIXED_PRIO ? 1'b1 : ~r_last_grant) : w_req1;
    assign w_win_wr = w_winner ? w_wr1 : w_wr0;
    assign w_rd     = r_state == BUSY_RD;
    assign w_wr     = r_state == BUSY_WR;
    assign w_s_arvalid = w_rd & ~r_ar_done & (r_owner ? m1.arvalid : m0.arvalid);
    assign w_s_rready  = w_rd & (r_owner ? m1.rready : m0.rready);
    assign w_s_awvalid = w_wr & ~r_aw_done & (r_owner ? m1.awvalid : m0.awvalid);
    assign w_s_wvalid  = w_wr & ~r_w_done & (r_owner ? m1.wvalid : m0.wvalid);
    assign w_s_bready  = w_wr & (r_owner ? m1.bready : m0.bready);
    assign s.arvalid = w_s_arvalid;
    assign s.araddr  = r_owner ? m1.araddr : m0.araddr;
    assign s.rready  = w_s_rready;
    assign s.awvalid = w_s_awvalid;
    assign s.awaddr  = r_owner ? m1.awaddr : m0.awaddr;
    assign s.wvalid  = w_s_wvalid;
    assign s.wdata   = r_owner ? m1.wdata : m0.wdata;
    assign s.wstrb   = r_owner ? m1.wstrb : m0.wstrb;
    assign s.bready  = w_s_bready;
    assign w_arready = w_rd & ~r_ar_done & s.arready;
    assign w_awready = w_wr & ~r_aw_done & s.awready;
    assign w_wready  = w_wr & ~r_w_done & s.wready;
    assign w_rvalid  = w_rd & s.rvalid;
    assign w_bvalid  = w_wr & s.bvalid;
    assign m0.arready = w_arready & ~r_owner;
    assign m1.arready = w_arready & r_owner;
    assign m0.awready = w_awready & ~r_owner;
    assign m1.awready = w_awready & r_owner;
    assign m0.wready  = w_wready & ~r_owner;
    assign m1.wready  = w_wready & r_owner;
    assign m0.rvalid  = w_rvalid & ~r_owner;
    assign m1.rvalid  = w_rvalid & r_owner;
    assign m0.bvalid  = w_bvalid & ~r_owner;
    assign m1.bvalid  = w_bvalid & r_owner;
    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;
    assign m0.rresp = s.rresp;
    assign m1.rresp = s.rresp;
    assign m0.bresp = s.bresp;
    assign m1.bresp = s.bresp;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_ar_done    <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_req0 | w_req1) begin
                    r_owner      <= w_winner;
                    r_last_grant <= w_winner;
                    r_state      <= w_win_wr ? BUSY_WR : BUSY_RD;
                    r_ar_done    <= 1'b0;
                    r_aw_done    <= 1'b0;
                    r_w_done     <= 1'b0;
                end
                BUSY_RD: begin
                    if (w_s_arvalid & s.arready) r_ar_done <= 1'b1;
                    if (s.rvalid & w_s_rready) r_state <= IDLE;
                end
                BUSY_WR: begin
                    if (w_s_awvalid & s.awready) r_aw_done <= 1'b1;
                    if (w_s_wvalid & s.wready) r_w_done <= 1'b1;
                    if (s.bvalid & w_s_bready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed checks of round-robin and fixed-priority arbitration
module tb_axi_lite_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   failed = 0;
    int   w_hs = 0;
    int   aw_hs = 0;
    int   w_base;
    int   aw_base;
    always #5 clk = ~clk;
    axi_lite_if m0_if ();
    axi_lite_if m1_if ();
    axi_lite_if s_if ();
    axi_lite_if f0_if ();
    axi_lite_if f1_if ();
    axi_lite_if fs_if ();
    axi_lite_arbiter #(.FIXED_PRIO(1'b0)) u_rr (.clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if), .s(s_if));
    axi_lite_arbiter #(.FIXED_PRIO(1'b1)) u_fp (.clk(clk), .reset(reset), .m0(f0_if), .m1(f1_if), .s(fs_if));
    always @(posedge clk) begin
        if (s_if.wvalid && s_if.wready) w_hs++;
        if (s_if.awvalid && s_if.awready) aw_hs++;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic nxt;
        @(negedge clk);
    endtask
    task automatic clr;
        {m0_if.arvalid, m0_if.rready, m0_if.awvalid, m0_if.wvalid, m0_if.bready} = '0;
        {m1_if.arvalid, m1_if.rready, m1_if.awvalid, m1_if.wvalid, m1_if.bready} = '0;
        {f0_if.arvalid, f0_if.rready, f0_if.awvalid, f0_if.wvalid, f0_if.bready} = '0;
        {f1_if.arvalid, f1_if.rready, f1_if.awvalid, f1_if.wvalid, f1_if.bready} = '0;
        {m0_if.araddr, m0_if.awaddr, m0_if.wdata, m0_if.wstrb} = '0;
        {m1_if.araddr, m1_if.awaddr, m1_if.wdata, m1_if.wstrb} = '0;
        {f0_if.araddr, f0_if.awaddr, f0_if.wdata, f0_if.wstrb} = '0;
        {f1_if.araddr, f1_if.awaddr, f1_if.wdata, f1_if.wstrb} = '0;
        {s_if.arready, s_if.rvalid, s_if.awready, s_if.wready, s_if.bvalid} = '0;
        {fs_if.arready, fs_if.rvalid, fs_if.awready, fs_if.wready, fs_if.bvalid} = '0;
        {s_if.rdata, s_if.rresp, s_if.bresp, fs_if.rdata, fs_if.rresp, fs_if.bresp} = '0;
    endtask
    initial begin
        clr();
        nxt();
        nxt();
        #1;
        chk("rst_state", u_rr.r_state, 0);
        chk("rst_last_grant", u_rr.r_last_grant, 1);
        chk("rst_s_arvalid", s_if.arvalid, 0);
        chk("rst_s_awvalid", s_if.awvalid, 0);
        chk("rst_s_wvalid", s_if.wvalid, 0);
        nxt();
        reset = 1'b0;
        // single read from m0
        m0_if.arvalid = 1'b1;
        m0_if.araddr  = 32'h8000_0000;
        m0_if.rready  = 1'b1;
        #1;
        chk("rd_idle_arvalid", s_if.arvalid, 0);
        chk("rd_idle_arready", m0_if.arready, 0);
        nxt();
        s_if.arready = 1'b1;
        #1;
        chk("rd_s_arvalid", s_if.arvalid, 1);
        chk("rd_s_araddr", s_if.araddr, 32'h8000_0000);
        chk("rd_m0_arready", m0_if.arready, 1);
        chk("rd_m1_arready", m1_if.arready, 0);
        nxt();
        m0_if.arvalid = 1'b0;
        s_if.arready  = 1'b0;
        s_if.rvalid   = 1'b1;
        s_if.rdata    = 32'h1234_5678;
        s_if.rresp    = 2'b00;
        #1;
        chk("rd_m0_rvalid", m0_if.rvalid, 1);
        chk("rd_m0_rdata", m0_if.rdata, 32'h1234_5678);
        chk("rd_m0_rresp", m0_if.rresp, 0);
        chk("rd_m1_rvalid", m1_if.rvalid, 0);
        chk("rd_s_rready", s_if.rready, 1);
        nxt();
        s_if.rvalid = 1'b0;
        #1;
        chk("rd_back_idle", u_rr.r_state, 0);
        chk("rd_m0_rvalid_off", m0_if.rvalid, 0);
        // simultaneous request right after reset, round-robin
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        m0_if.arvalid = 1'b1;
        m0_if.araddr  = 32'h0000_1000;
        m1_if.awvalid = 1'b1;
        m1_if.awaddr  = 32'ha000_03f8;
        m1_if.wvalid  = 1'b1;
        m1_if.wdata   = 32'h0000_0041;
        m1_if.wstrb   = 4'h1;
        m1_if.bready  = 1'b1;
        s_if.arready  = 1'b1;
        #1;
        chk("tie_idle_arvalid", s_if.arvalid, 0);
        chk("tie_idle_awvalid", s_if.awvalid, 0);
        nxt();
        #1;
        chk("tie_m0_first", s_if.arvalid, 1);
        chk("tie_m0_arready", m0_if.arready, 1);
        chk("tie_m1_awvalid_held", s_if.awvalid, 0);
        chk("tie_m1_awready", m1_if.awready, 0);
        chk("tie_m1_wready", m1_if.wready, 0);
        nxt();
        m0_if.arvalid = 1'b0;
        s_if.rvalid   = 1'b1;
        s_if.rdata    = 32'hcafe_f00d;
        #1;
        chk("tie_m0_rvalid", m0_if.rvalid, 1);
        chk("tie_wvalid_held", s_if.wvalid, 0);
        chk("tie_m1_bvalid", m1_if.bvalid, 0);
        nxt();
        s_if.rvalid = 1'b0;
        #1;
        chk("tie_dead_awvalid", s_if.awvalid, 0);
        chk("tie_dead_state", u_rr.r_state, 0);
        nxt();
        s_if.awready = 1'b1;
        s_if.wready  = 1'b1;
        #1;
        chk("wr_s_awvalid", s_if.awvalid, 1);
        chk("wr_s_awaddr", s_if.awaddr, 32'ha000_03f8);
        chk("wr_s_wvalid", s_if.wvalid, 1);
        chk("wr_s_wdata", s_if.wdata[7:0], 8'h41);
        chk("wr_m1_awready", m1_if.awready, 1);
        chk("wr_m1_wready", m1_if.wready, 1);
        chk("wr_m0_arready", m0_if.arready, 0);
        nxt();
        m1_if.awvalid = 1'b0;
        m1_if.wvalid  = 1'b0;
        s_if.awready  = 1'b0;
        s_if.wready   = 1'b0;
        s_if.bvalid   = 1'b1;
        s_if.bresp    = 2'b10;
        #1;
        chk("err_m1_bvalid", m1_if.bvalid, 1);
        chk("err_m1_bresp", m1_if.bresp, 2'b10);
        chk("err_m0_bvalid", m0_if.bvalid, 0);
        chk("err_s_bready", s_if.bready, 1);
        nxt();
        s_if.bvalid = 1'b0;
        s_if.bresp  = 2'b00;
        #1;
        chk("wr_back_idle", u_rr.r_state, 0);
        // split write: W two cycles before AW, awready low for 3 cycles
        w_base  = w_hs;
        aw_base = aw_hs;
        m0_if.wvalid = 1'b1;
        m0_if.wdata  = 32'h5555_aaaa;
        m0_if.wstrb  = 4'hf;
        m0_if.bready = 1'b1;
        s_if.wready  = 1'b1;
        nxt();
        #1;
        chk("sp_s_wvalid", s_if.wvalid, 1);
        chk("sp_m0_wready", m0_if.wready, 1);
        chk("sp_s_awvalid", s_if.awvalid, 0);
        nxt();
        m0_if.awvalid = 1'b1;
        m0_if.awaddr  = 32'h0000_0040;
        #1;
        chk("sp_second_w_blocked", m0_if.wready, 0);
        chk("sp_s_wvalid_off", s_if.wvalid, 0);
        chk("sp_s_awvalid", s_if.awvalid, 1);
        chk("sp_aw_stall1", m0_if.awready, 0);
        nxt();
        #1;
        chk("sp_aw_stall2", m0_if.awready, 0);
        nxt();
        #1;
        chk("sp_aw_stall3", m0_if.awready, 0);
        chk("sp_s_awaddr", s_if.awaddr, 32'h0000_0040);
        nxt();
        s_if.awready = 1'b1;
        #1;
        chk("sp_aw_ready", m0_if.awready, 1);
        nxt();
        m0_if.awvalid = 1'b0;
        m0_if.wvalid  = 1'b0;
        s_if.awready  = 1'b0;
        s_if.bvalid   = 1'b1;
        #1;
        chk("sp_m0_bvalid", m0_if.bvalid, 1);
        chk("sp_m1_bvalid", m1_if.bvalid, 0);
        chk("sp_awvalid_done", s_if.awvalid, 0);
        nxt();
        s_if.bvalid = 1'b0;
        s_if.wready = 1'b0;
        #1;
        chk("sp_w_hs_count", w_hs - w_base, 1);
        chk("sp_aw_hs_count", aw_hs - aw_base, 1);
        // reset in BUSY_RD before R; m1 owns the read
        m1_if.arvalid = 1'b1;
        m1_if.araddr  = 32'h0000_0100;
        m1_if.rready  = 1'b1;
        s_if.arready  = 1'b1;
        nxt();
        #1;
        chk("rs_m1_arready", m1_if.arready, 1);
        nxt();
        m1_if.arvalid = 1'b0;
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        m0_if.arvalid = 1'b1;
        m0_if.araddr  = 32'h0000_0200;
        m1_if.arvalid = 1'b1;
        m1_if.araddr  = 32'h0000_0300;
        s_if.rvalid   = 1'b1;
        #1;
        chk("rs_state", u_rr.r_state, 0);
        chk("rs_last_grant", u_rr.r_last_grant, 1);
        chk("rs_s_arvalid", s_if.arvalid, 0);
        chk("rs_s_rready", s_if.rready, 0);
        chk("rs_m1_rvalid", m1_if.rvalid, 0);
        chk("rs_m0_arready", m0_if.arready, 0);
        chk("rs_m1_arready", m1_if.arready, 0);
        nxt();
        s_if.rvalid = 1'b0;
        #1;
        chk("rs_tie_m0", m0_if.arready, 1);
        chk("rs_tie_m1", m1_if.arready, 0);
        chk("rs_tie_addr", s_if.araddr, 32'h0000_0200);
        clr();
        // fixed priority: m1 wins every tie while it keeps requesting
        f0_if.arvalid = 1'b1;
        f0_if.araddr  = 32'h0000_0010;
        f0_if.rready  = 1'b1;
        f1_if.arvalid = 1'b1;
        f1_if.araddr  = 32'h0000_0020;
        f1_if.rready  = 1'b1;
        fs_if.arready = 1'b1;
        #1;
        chk("fp_idle_arvalid", fs_if.arvalid, 0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            #1;
            chk($sformatf("fp_grant%0d_m1", i), f1_if.arready, 1);
            chk($sformatf("fp_grant%0d_m0", i), f0_if.arready, 0);
            nxt();
            fs_if.rvalid = 1'b1;
            fs_if.rdata  = 32'h1000 + i;
            #1;
            chk($sformatf("fp_r%0d_m1", i), f1_if.rvalid, 1);
            chk($sformatf("fp_r%0d_m0", i), f0_if.rvalid, 0);
            nxt();
            fs_if.rvalid = 1'b0;
            if (i == 3) f1_if.arvalid = 1'b0;
            #1;
            chk($sformatf("fp_idle%0d", i), fs_if.arvalid, 0);
        end
        nxt();
        #1;
        chk("fp_m0_served", f0_if.arready, 1);
        chk("fp_m0_addr", fs_if.araddr, 32'h0000_0010);
        nxt();
        f0_if.arvalid = 1'b0;
        fs_if.rvalid  = 1'b1;
        fs_if.rdata   = 32'hbeef_0000;
        #1;
        chk("fp_m0_rvalid", f0_if.rvalid, 1);
        chk("fp_m0_rdata", f0_if.rdata, 32'hbeef_0000);
        nxt();
        clr();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
